// File: rtl/lv_efuse_load_ctrl.sv
// lv_efuse_load_ctrl
// Responder for the LV control unit's efuse load handshake. On a request it
// reads the efuse macro word by word (address setup, then a timed read
// strobe), writes every captured word into the register bank, checks the
// XOR checksum held in the last word and reports the result with a
// one-cycle done pulse. Every output is a register.

module lv_efuse_load_ctrl #(
    parameter int EFUSE_WORD_NUM = 8,
    parameter int EFUSE_DATA_W   = 8,
    parameter int EFUSE_ADDR_W   = 3,
    parameter int RD_SETUP_CYC   = 1,
    parameter int RD_PULSE_CYC   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_efuse_load_req,
    output logic                    o_efuse_load_done,
    output logic                    o_efuse_vld,
    output logic                    o_efuse_busy,
    output logic                    o_efuse_rden,
    output logic [EFUSE_ADDR_W-1:0] o_efuse_addr,
    input  logic [EFUSE_DATA_W-1:0] i_efuse_rdata,
    output logic                    o_efuse_wr_en,
    output logic [EFUSE_ADDR_W-1:0] o_efuse_wr_addr,
    output logic [EFUSE_DATA_W-1:0] o_efuse_wr_data
);

    // Phase counter is shared by SETUP and STRB, so size it for the longer.
    localparam int CNT_MAX = (RD_SETUP_CYC > RD_PULSE_CYC) ? RD_SETUP_CYC : RD_PULSE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]        SETUP_LAST = CNT_W'(RD_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]        PULSE_LAST = CNT_W'(RD_PULSE_CYC - 1);
    localparam logic [EFUSE_ADDR_W-1:0] LAST_IDX   = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STRB,
        CAPT,
        CHECK,
        DONE
    } state_t;

    state_t                  state;
    logic                    armed;
    logic                    abort;
    logic [CNT_W-1:0]        cnt;
    logic [EFUSE_ADDR_W-1:0] idx;
    logic [EFUSE_DATA_W-1:0] xor_acc;
    logic [EFUSE_DATA_W-1:0] or_acc;

    // A dropped request during the read sequence cancels the load.
    always_comb begin
        abort = 1'b0;
        if (!i_efuse_load_req && (state == SETUP || state == STRB || state == CAPT))
            abort = 1'b1;
    end

    // Armed flag: re-armed by any sampled low request, spent on entering DONE,
    // so a request still high after done cannot start a second load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            armed <= 1'b1;
        else if (!i_efuse_load_req)
            armed <= 1'b1;
        else if (state == CHECK)
            armed <= 1'b0;
    end

    // Load sequencer; outputs are assigned on the edge that enters the state
    // they belong to, so they are valid for the whole of that state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= IDLE;
            cnt               <= '0;
            idx               <= '0;
            xor_acc           <= '0;
            or_acc            <= '0;
            o_efuse_load_done <= 1'b0;
            o_efuse_vld       <= 1'b0;
            o_efuse_busy      <= 1'b0;
            o_efuse_rden      <= 1'b0;
            o_efuse_addr      <= '0;
            o_efuse_wr_en     <= 1'b0;
            o_efuse_wr_addr   <= '0;
            o_efuse_wr_data   <= '0;
        end else begin
            // NOTE: pulse outputs default low here and are raised only on the
            // entry edge; non-blocking assignment lets the later case branch
            // override this default without ordering hazards.
            o_efuse_wr_en     <= 1'b0;
            o_efuse_load_done <= 1'b0;

            if (abort) begin
                // Words already written stay written; vld was cleared at start.
                state        <= IDLE;
                o_efuse_rden <= 1'b0;
                o_efuse_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_efuse_load_req && armed) begin
                            state        <= SETUP;
                            cnt          <= '0;
                            idx          <= '0;
                            xor_acc      <= '0;
                            or_acc       <= '0;
                            o_efuse_vld  <= 1'b0;
                            o_efuse_busy <= 1'b1;
                            o_efuse_addr <= '0;
                        end
                    end

                    SETUP: begin
                        if (cnt == SETUP_LAST) begin
                            state        <= STRB;
                            cnt          <= '0;
                            o_efuse_rden <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    STRB: begin
                        if (cnt == PULSE_LAST) begin
                            // Capture the data presented during the last strobe cycle.
                            state           <= CAPT;
                            cnt             <= '0;
                            o_efuse_rden    <= 1'b0;
                            o_efuse_wr_en   <= 1'b1;
                            o_efuse_wr_addr <= idx;
                            o_efuse_wr_data <= i_efuse_rdata;
                            or_acc          <= or_acc | i_efuse_rdata;
                            if (idx < LAST_IDX)
                                xor_acc <= xor_acc ^ i_efuse_rdata;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    CAPT: begin
                        if (idx == LAST_IDX) begin
                            state <= CHECK;
                        end else begin
                            // Address moves only on SETUP entry, never under the strobe.
                            state        <= SETUP;
                            idx          <= idx + EFUSE_ADDR_W'(1);
                            o_efuse_addr <= idx + EFUSE_ADDR_W'(1);
                        end
                    end

                    CHECK: begin
                        // wr_data still holds the checksum word; an all-zero array fails.
                        state             <= DONE;
                        o_efuse_vld       <= (xor_acc == o_efuse_wr_data) && (or_acc != '0);
                        o_efuse_load_done <= 1'b1;
                    end

                    DONE: begin
                        state        <= IDLE;
                        o_efuse_busy <= 1'b0;
                    end

                    default: begin
                        state        <= IDLE;
                        o_efuse_rden <= 1'b0;
                        o_efuse_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lv_efuse_load_ctrl.sv
// Testbench for lv_efuse_load_ctrl: models the efuse macro, predicts every
// register-bank write and done pulse into scoreboard queues, and pops them
// as the design produces them.

module tb_lv_efuse_load_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       done;
    logic       vld;
    logic       busy;
    logic       rden;
    logic [2:0] addr;
    logic [7:0] rdata;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    typedef struct {
        int   cyc;
        logic vld;
    } done_t;

    wr_t        wq[$];
    done_t      dq[$];
    logic [7:0] mem [8];
    int         cyc   = 0;
    int         base  = 0;
    int         total = 0;
    int         bad   = 0;
    logic [2:0] prev_addr = '0;

    logic [7:0] good_w [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h00};
    logic [7:0] bad_w  [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h01};
    logic [7:0] zero_w [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    lv_efuse_load_ctrl dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_efuse_load_req  (req),
        .o_efuse_load_done (done),
        .o_efuse_vld       (vld),
        .o_efuse_busy      (busy),
        .o_efuse_rden      (rden),
        .o_efuse_addr      (addr),
        .i_efuse_rdata     (rdata),
        .o_efuse_wr_en     (wr_en),
        .o_efuse_wr_addr   (wr_addr),
        .o_efuse_wr_data   (wr_data)
    );

    // Efuse macro: data valid only under the strobe, junk otherwise.
    assign rdata = rden ? mem[addr] : 8'hA5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor on the falling edge: pops the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                if (wq.size() == 0) begin
                    chk("unexpected_wr_en", wr_en, 1'b0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_data", wr_data, e.data);
                    chk("wr_cycle", cyc - base, e.cyc);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", done, 1'b0);
                end else begin
                    done_t d;
                    d = dq.pop_front();
                    chk("done_cycle", cyc - base, d.cyc);
                    chk("done_vld", vld, d.vld);
                end
            end
            if (rden)
                chk("addr_stable_under_strobe", addr, prev_addr);
            prev_addr = addr;
        end
    end

    // Push the expected writes for words [0, n_wr) of the current memory image.
    task automatic push_writes(input int n_wr);
        for (int i = 0; i < n_wr; i++) begin
            wr_t e;
            e.addr = 3'(i);
            e.data = mem[i];
            e.cyc  = 6 * (i + 1);
            wq.push_back(e);
        end
    endtask

    // Full load: req raised for cycle 0, done expected at cycle 50.
    // Returns in cycle 51 with req still high.
    task automatic do_load(input logic [7:0] w [8], input logic exp_vld);
        done_t d;
        mem = w;
        @(posedge clk); #1;
        req  = 1'b1;
        base = cyc;
        push_writes(8);
        d.cyc = 50;
        d.vld = exp_vld;
        dq.push_back(d);
        @(posedge clk); #1;
        chk("c1_busy", busy, 1'b1);
        chk("c1_vld_cleared", vld, 1'b0);
        chk("c1_addr", addr, 3'd0);
        chk("c1_rden", rden, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        chk("c51_busy", busy, 1'b0);
        chk("c51_done", done, 1'b0);
        chk("c51_vld_hold", vld, exp_vld);
        chk("c51_writes_left", wq.size(), 0);
        chk("c51_done_left", dq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        mem   = zero_w;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", done, 1'b0);
        chk("rst_vld", vld, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rden", rden, 1'b0);
        chk("rst_addr", addr, 3'd0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, 3'd0);
        chk("rst_wr_data", wr_data, 8'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Valid load.
        do_load(good_w, 1'b1);
        req = 1'b0;

        // Bad checksum.
        do_load(bad_w, 1'b0);
        req = 1'b0;

        // Unprogrammed array: checksum matches, still invalid.
        do_load(zero_w, 1'b0);
        req = 1'b0;

        // Abort in STRB of word 3 (cycle 20).
        mem = good_w;
        @(posedge clk); #1;
        req  = 1'b1;
        base = cyc;
        push_writes(3);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_c20_rden", rden, 1'b1);
        chk("abort_c20_addr", addr, 3'd3);
        req = 1'b0;
        @(posedge clk); #1;
        chk("abort_c21_busy", busy, 1'b0);
        chk("abort_c21_rden", rden, 1'b0);
        chk("abort_c21_vld", vld, 1'b0);
        chk("abort_c21_wr_en", wr_en, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_writes_left", wq.size(), 0);
        chk("abort_busy_idle", busy, 1'b0);

        // Restart after abort, then hold req for three cycles past done.
        do_load(good_w, 1'b1);
        repeat (2) begin
            @(posedge clk); #1;
            chk("rearm_no_reload_busy", busy, 1'b0);
        end
        @(posedge clk); #1;
        chk("rearm_no_reload_addr", addr, 3'd7);
        req = 1'b0;
        do_load(bad_w, 1'b0);

        // Reset in cycle 30 (CAPT of word 4, which is cut off).
        req = 1'b0;
        mem = good_w;
        @(posedge clk); #1;
        req  = 1'b1;
        base = cyc;
        push_writes(4);
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rden", rden, 1'b0);
        chk("midrst_addr", addr, 3'd0);
        chk("midrst_wr_en", wr_en, 1'b0);
        chk("midrst_wr_data", wr_data, 8'd0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_vld", vld, 1'b0);
        chk("midrst_writes_left", wq.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base  = cyc;
        push_writes(8);
        begin
            done_t d;
            d.cyc = 50;
            d.vld = 1'b1;
            dq.push_back(d);
        end
        repeat (51) @(posedge clk);
        #1;
        chk("postrst_busy", busy, 1'b0);
        chk("postrst_vld", vld, 1'b1);
        chk("postrst_writes_left", wq.size(), 0);
        chk("postrst_done_left", dq.size(), 0);
        req = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
